// File: rtl/if_fetch_unit.sv
// IF-stage fetch unit.
//
// Holds the fetch PC (PCF), issues one instruction-memory request at a time
// over a req/gnt/rvalid handshake, and presents the returned instruction to
// the ID segment register until ID consumes it. Responses belonging to a
// fetch made stale by a redirect are dropped.
//
// Ports:
//   CPU_CLK      in   clock, rising-edge
//   CPU_RST      in   synchronous active-high reset
//   PC_In        in   next PC from the next-PC generator
//   Redirect     in   PC_In is a taken control-transfer target
//   StallF       in   ID cannot accept an instruction this cycle
//   PCF          out  PC of the instruction being fetched or held
//   imem_req     out  request valid
//   imem_addr    out  word-aligned request address
//   imem_gnt     in   memory accepts the request
//   imem_rvalid  in   response valid
//   imem_rdata   in   response instruction
//   InstrF       out  fetched instruction for PCF
//   InstrValidF  out  InstrF is valid

module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST,
  input  logic [31:0] PC_In,
  input  logic        Redirect,
  input  logic        StallF,
  output logic [31:0] PCF,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrF,
  output logic        InstrValidF
);

  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StValid
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pcf_q, pcf_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  // Set when the outstanding request was issued for a PC that has since been
  // redirected away; its response must be thrown away.
  logic        drop_q, drop_d;

  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      state_q <= StIdle;
      pcf_q   <= RESET_PC;
      instr_q <= Nop;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pcf_q   <= pcf_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pcf_d   = pcf_q;
    instr_d = instr_q;
    valid_d = valid_q;
    drop_d  = drop_q;

    unique case (state_q)
      StIdle: begin
        state_d = StReq;
        if (Redirect) pcf_d = PC_In;
      end

      StReq: begin
        if (Redirect) pcf_d = PC_In;
        if (imem_gnt) begin
          state_d = StWait;
          // The old address was accepted in the same cycle as the redirect.
          if (Redirect) drop_d = 1'b1;
        end
      end

      StWait: begin
        if (Redirect) pcf_d = PC_In;
        if (imem_rvalid) begin
          if (drop_q || Redirect) begin
            drop_d  = 1'b0;
            state_d = StReq;
          end else begin
            instr_d = imem_rdata;
            valid_d = 1'b1;
            state_d = StValid;
          end
        end else if (Redirect) begin
          drop_d = 1'b1;
        end
      end

      StValid: begin
        // A redirect overrides a stall: the held instruction is now stale.
        if (Redirect || !StallF) begin
          pcf_d   = PC_In;
          valid_d = 1'b0;
          state_d = StReq;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign imem_req    = (state_q == StReq);
  assign imem_addr   = {pcf_q[31:2], 2'b00};
  assign PCF         = pcf_q;
  assign InstrF      = instr_q;
  assign InstrValidF = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  logic        CPU_CLK = 1'b0;
  logic        CPU_RST;
  logic [31:0] PC_In;
  logic        Redirect;
  logic        StallF;
  logic [31:0] PCF;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] InstrF;
  logic        InstrValidF;

  // Stimulus controls
  logic        use_tgt;
  logic [31:0] tgt;
  logic        gnt_en;
  int          lat;
  logic [31:0] rdata_v;

  // Simple memory responder: one response lat cycles after acceptance
  logic        pend;
  int          wait_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  if_fetch_unit #(
    .RESET_PC(32'h0000_0000)
  ) dut (
    .CPU_CLK    (CPU_CLK),
    .CPU_RST    (CPU_RST),
    .PC_In      (PC_In),
    .Redirect   (Redirect),
    .StallF     (StallF),
    .PCF        (PCF),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .InstrF     (InstrF),
    .InstrValidF(InstrValidF)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  assign PC_In       = use_tgt ? tgt : PCF + 32'd4;
  assign imem_gnt    = gnt_en;
  assign imem_rvalid = pend && (wait_cnt == 0);
  assign imem_rdata  = rdata_v;

  always @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      pend     <= 1'b0;
      wait_cnt <= 0;
    end else if (imem_req && imem_gnt) begin
      pend     <= 1'b1;
      wait_cnt <= lat - 1;
    end else if (pend) begin
      if (wait_cnt == 0) pend <= 1'b0;
      else               wait_cnt <= wait_cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CPU_CLK);
  endtask

  initial begin
    CPU_RST  = 1'b1;
    Redirect = 1'b0;
    StallF   = 1'b0;
    use_tgt  = 1'b0;
    tgt      = 32'h0;
    gnt_en   = 1'b1;
    lat      = 1;
    rdata_v  = 32'h0050_0093;
    repeat (2) tick();

    // Reset state
    chk("rst_pcf", PCF, 32'h0);
    chk("rst_valid", {31'b0, InstrValidF}, 32'd0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_instr", InstrF, 32'h0000_0013);

    // Test 1: back-to-back fetch
    CPU_RST = 1'b0;
    tick();
    chk("t1_req0", {31'b0, imem_req}, 32'd1);
    chk("t1_addr0", imem_addr, 32'h0);
    tick();
    chk("t1_wait_req", {31'b0, imem_req}, 32'd0);
    chk("t1_wait_valid", {31'b0, InstrValidF}, 32'd0);
    tick();
    chk("t1_valid", {31'b0, InstrValidF}, 32'd1);
    chk("t1_instr", InstrF, 32'h0050_0093);
    chk("t1_pcf0", PCF, 32'h0);
    tick();
    chk("t1_pcf4", PCF, 32'h4);
    chk("t1_addr4", imem_addr, 32'h4);
    chk("t1_req4", {31'b0, imem_req}, 32'd1);
    chk("t1_valid_clr", {31'b0, InstrValidF}, 32'd0);
    repeat (2) tick();
    chk("t1_valid4", {31'b0, InstrValidF}, 32'd1);
    chk("t1_pcf4b", PCF, 32'h4);
    tick();
    chk("t1_pcf8", PCF, 32'h8);
    chk("t1_addr8", imem_addr, 32'h8);

    // Test 2: stall in VALID
    rdata_v = 32'h0000_1111;
    repeat (2) tick();
    chk("t2_valid", {31'b0, InstrValidF}, 32'd1);
    StallF = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_req", {31'b0, imem_req}, 32'd0);
      chk("t2_hold_valid", {31'b0, InstrValidF}, 32'd1);
      chk("t2_hold_pcf", PCF, 32'h8);
      chk("t2_hold_instr", InstrF, 32'h0000_1111);
    end
    StallF = 1'b0;
    tick();
    chk("t2_req", {31'b0, imem_req}, 32'd1);
    chk("t2_addr", imem_addr, 32'hC);

    // Test 3: redirect in WAIT, late response discarded
    lat     = 4;
    rdata_v = 32'hDEAD_BEEF;
    tick();
    chk("t3_wait", {31'b0, imem_req}, 32'd0);
    Redirect = 1'b1;
    use_tgt  = 1'b1;
    tgt      = 32'h100;
    tick();
    Redirect = 1'b0;
    use_tgt  = 1'b0;
    lat      = 1;
    chk("t3_pcf", PCF, 32'h100);
    chk("t3_req", {31'b0, imem_req}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t3_nvalid", {31'b0, InstrValidF}, 32'd0);
      chk("t3_nreq", {31'b0, imem_req}, 32'd0);
    end
    tick();
    rdata_v = 32'h1111_1111;
    chk("t3_drop_valid", {31'b0, InstrValidF}, 32'd0);
    chk("t3_req100", {31'b0, imem_req}, 32'd1);
    chk("t3_addr100", imem_addr, 32'h100);
    repeat (2) tick();
    chk("t3_valid", {31'b0, InstrValidF}, 32'd1);
    chk("t3_instr", InstrF, 32'h1111_1111);
    chk("t3_pcf100", PCF, 32'h100);
    tick();
    chk("t3_pcf104", PCF, 32'h104);

    // Test 4: redirect in the same cycle as gnt
    Redirect = 1'b1;
    use_tgt  = 1'b1;
    tgt      = 32'h200;
    rdata_v  = 32'hBAD0_BAD0;
    tick();
    Redirect = 1'b0;
    use_tgt  = 1'b0;
    chk("t4_pcf", PCF, 32'h200);
    chk("t4_req", {31'b0, imem_req}, 32'd0);
    tick();
    rdata_v = 32'h2222_2222;
    chk("t4_drop_valid", {31'b0, InstrValidF}, 32'd0);
    chk("t4_req200", {31'b0, imem_req}, 32'd1);
    chk("t4_addr200", imem_addr, 32'h200);
    repeat (2) tick();
    chk("t4_valid", {31'b0, InstrValidF}, 32'd1);
    chk("t4_instr", InstrF, 32'h2222_2222);
    chk("t4_pcf200", PCF, 32'h200);
    tick();
    chk("t4_pcf204", PCF, 32'h204);

    // Test 5: gnt withheld, then redirect while requesting
    gnt_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t5_req_hold", {31'b0, imem_req}, 32'd1);
      chk("t5_addr_hold", imem_addr, 32'h204);
    end
    Redirect = 1'b1;
    use_tgt  = 1'b1;
    tgt      = 32'h40;
    tick();
    Redirect = 1'b0;
    use_tgt  = 1'b0;
    gnt_en   = 1'b1;
    rdata_v  = 32'h3333_3333;
    chk("t5_req40", {31'b0, imem_req}, 32'd1);
    chk("t5_addr40", imem_addr, 32'h40);
    repeat (2) tick();
    chk("t5_valid", {31'b0, InstrValidF}, 32'd1);
    chk("t5_instr", InstrF, 32'h3333_3333);
    chk("t5_pcf40", PCF, 32'h40);
    tick();
    chk("t5_addr44", imem_addr, 32'h44);

    // Test 6: reset in WAIT
    lat = 3;
    tick();
    chk("t6_wait", {31'b0, imem_req}, 32'd0);
    CPU_RST = 1'b1;
    tick();
    chk("t6_pcf", PCF, 32'h0);
    chk("t6_valid", {31'b0, InstrValidF}, 32'd0);
    chk("t6_req", {31'b0, imem_req}, 32'd0);
    chk("t6_instr", InstrF, 32'h0000_0013);
    CPU_RST = 1'b0;
    lat     = 1;
    rdata_v = 32'h4444_4444;
    tick();
    chk("t6_req0", {31'b0, imem_req}, 32'd1);
    chk("t6_addr0", imem_addr, 32'h0);
    repeat (2) tick();
    chk("t6_rvalid", {31'b0, InstrValidF}, 32'd1);
    chk("t6_rinstr", InstrF, 32'h4444_4444);
    chk("t6_rpcf", PCF, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- IF-stage fetch unit, directly downstream of the next-PC generator.
- Owns the PCF register and loads it from the generator's PC_In.
- Issues one instruction-memory request at a time over a req/gnt/rvalid handshake and holds the returned instruction for the ID segment register.
- Discards in-flight fetches invalidated by a redirect (taken branch, jal, jalr).

Parameters:
- RESET_PC, 32'h0000_0000, PCF value loaded on reset.

Ports:
- CPU_CLK  in  1  clock; all state changes on the rising edge.
- CPU_RST  in  1  reset, synchronous, active-high.
- PC_In  in  32  next PC from the next-PC generator (PCF+4 or jump target).
- Redirect  in  1  PC_In is a taken control-transfer target; the current fetch is invalid.
- StallF  in  1  ID cannot accept an instruction this cycle.
- PCF  out  32  PC of the instruction being fetched or held.
- imem_req  out  1  request valid.
- imem_addr  out  32  request address, equal to {PCF[31:2],2'b00}.
- imem_gnt  in  1  memory accepts the request; the request transfers on imem_req&&imem_gnt.
- imem_rvalid  in  1  response data valid; exactly one response per accepted request, at least 1 cycle after gnt.
- imem_rdata  in  32  response instruction.
- InstrF  out  32  fetched instruction for PCF.
- InstrValidF  out  1  InstrF is valid; ID consumes on InstrValidF && !StallF.

Behaviour:
- Reset: CPU_RST high at an edge sets PCF=RESET_PC, state=IDLE, drop=0, InstrValidF=0, InstrF=32'h0000_0013 (nop).
  - imem_req is 0 in IDLE, so it is low throughout reset.
  - Reset dominates all other inputs, including mid-transaction.
  - Instruction memory shares CPU_RST, so no stale responses can arrive.
- States:
  - IDLE: next state is REQ.
  - REQ: imem_req=1, imem_addr from PCF. On gnt, go to WAIT.
  - WAIT: imem_req=0. On rvalid: if drop=1, discard the data, clear drop and go to REQ; otherwise load InstrF=imem_rdata, set InstrValidF=1 and go to VALID.
  - VALID: holds InstrF and InstrValidF. On consume (!StallF), PCF<=PC_In, InstrValidF<=0 and go to REQ.
- Redirect (highest priority after reset, overrides StallF): PCF<=PC_In in any state.
  - REQ without gnt: stay in REQ; the new address is presented the next cycle. The memory samples the address only on gnt.
  - REQ with gnt in the same cycle: the old address was accepted, so set drop=1 and go to WAIT.
  - WAIT without rvalid: set drop=1.
  - WAIT with rvalid: discard the data and go to REQ with drop=0.
  - VALID: clear InstrValidF and go to REQ.
  - IDLE: PCF updated; go to REQ.
- Stalling:
  - StallF only affects VALID; InstrF, InstrValidF and PCF are held stable while it is high.
  - REQ and WAIT ignore StallF.
- imem_rvalid outside WAIT is a protocol error and is ignored (no state change).
- PCF changes only on consume, on Redirect, or on reset.
- imem_addr low two bits are always 0. PC arithmetic is done upstream; this block does none.
- Throughput:
  - Minimum 3 cycles per instruction (REQ, WAIT, VALID) with gnt in the same cycle and rvalid the cycle after gnt.
  - At most one outstanding request.
  - drop is a single bit and can never need to count above 1.
- Outputs InstrF, InstrValidF and PCF are registered. imem_req and imem_addr are decoded from state and PCF.

Test Plan:
1. Reset, then CPU_RST=0 with gnt always 1, rvalid 1 cycle after gnt, rdata=0x00500093, PC_In=PCF+4, StallF=0 -> cycle 1 imem_req=1 addr 0x0; cycle 3 InstrValidF=1, InstrF=0x00500093; the next request uses addr 0x4; PCF steps 0,4,8 every 3 cycles.
2. StallF=1 for 5 cycles while in VALID -> InstrF, PCF and InstrValidF are held; no imem_req; after the stall drops, the next request uses addr PCF+4.
3. Redirect with PC_In=0x100 in WAIT (rvalid arrives 4 cycles later with 0xDEADBEEF) -> response discarded, InstrValidF stays 0; the next request uses addr 0x100.
4. Redirect with PC_In=0x200 in the same cycle as gnt -> drop set, the first rvalid is discarded, a second request goes to addr 0x200, and its data is delivered.
5. gnt held low 6 cycles, then Redirect with PC_In=0x40 -> imem_req stays 1, addr switches to 0x40 the next cycle, no drop, the response is delivered normally.
6. CPU_RST asserted in WAIT -> next cycle PCF=RESET_PC, InstrValidF=0, imem_req=0; after release the fetch restarts at RESET_PC.
